fft_bfly_r2_pipe: RTL and testbench

- Parametrised, fully pipelined radix-2 complex butterfly for the FFT datapath.
- Each sample selects DIF or DIT arithmetic and optional divide-by-2 stage scaling.
- Adds per-lane convergent-free (round-half-up) rounding, saturation with a sticky overflow flag, a sideband tag, and valid/ready backpressure.
- One instance sits between the stage delay-line/commutator and the next stage.

---
 rtl/fft_pkg.sv | 33 +++
 rtl/fft_cmult_pipe.sv | 50 +++++
 rtl/fft_bfly_r2_pipe.sv | 173 +++++++++++++++++
 tb/tb_fft_bfly_r2_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and fixed-point helpers for the radix-2 FFT butterfly datapath.
// Helpers work on 64-bit signed values so any datapath width up to that fits.
package fft_pkg;

   localparam int unsigned DW_DEF = 16;
   localparam int unsigned TW_DEF = 16;

   typedef enum logic {
      BFLY_DIF = 1'b0,
      BFLY_DIT = 1'b1
   } bfly_mode_e;

   // Round half up, then arithmetic shift right by sh.
   function automatic logic signed [63:0] rnd_shift(input logic signed [63:0] v,
                                                    input int unsigned sh);
      logic signed [63:0] half;
      half = (sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1));
      return (v + half) >>> sh;
   endfunction

   // Clamp to the signed range of a dw-bit value.
   function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v,
                                                 input int unsigned dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/fft_cmult_pipe.sv
// Full-precision complex multiplier (four real multipliers) with an enabled output register.
// Rounding is left to the caller so both butterfly modes can place it in different stages.
module fft_cmult_pipe
   import fft_pkg::*;
#(
   parameter int unsigned AW = DW_DEF + 1,
   parameter int unsigned TW = TW_DEF,
   localparam int unsigned PW = AW + TW + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic signed [AW-1:0] ar_i,
   input  logic signed [AW-1:0] ai_i,
   input  logic signed [TW-1:0] wr_i,
   input  logic signed [TW-1:0] wi_i,
   output logic signed [PW-1:0] pr_o,
   output logic signed [PW-1:0] pi_o
);

   logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;
   logic signed [PW-1:0] pr_d, pr_q, pi_d, pi_q;

   always_comb begin
      m_rr = PW'(ar_i) * PW'(wr_i);
      m_ii = PW'(ai_i) * PW'(wi_i);
      m_ri = PW'(ar_i) * PW'(wi_i);
      m_ir = PW'(ai_i) * PW'(wr_i);
      pr_d = pr_q;
      pi_d = pi_q;
      if (en_i) begin
         pr_d = m_rr - m_ii;
         pi_d = m_ri + m_ir;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pr_q <= '0;
         pi_q <= '0;
      end else begin
         pr_q <= pr_d;
         pi_q <= pi_d;
      end
   end

   assign pr_o = pr_q;
   assign pi_o = pi_q;

endmodule

// File: rtl/fft_bfly_r2_pipe.sv
// Three-stage radix-2 complex butterfly, per-sample DIF/DIT selection, optional halving,
// saturation with sticky overflow, sideband tag and whole-pipe valid/ready stalling.
module fft_bfly_r2_pipe
   import fft_pkg::*;
#(
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned TW   = TW_DEF,
   parameter int unsigned TAGW = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_mode,
   input  logic                 in_scale,
   input  logic [TAGW-1:0]      in_tag,
   input  logic signed [DW-1:0] a_re,
   input  logic signed [DW-1:0] a_im,
   input  logic signed [DW-1:0] b_re,
   input  logic signed [DW-1:0] b_im,
   input  logic signed [TW-1:0] w_re,
   input  logic signed [TW-1:0] w_im,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] x_re,
   output logic signed [DW-1:0] x_im,
   output logic signed [DW-1:0] y_re,
   output logic signed [DW-1:0] y_im,
   output logic [TAGW-1:0]      out_tag,
   output logic                 ovf_sticky,
   input  logic                 ovf_clr
);

   localparam int unsigned AW = DW + 1;
   localparam int unsigned PW = AW + TW + 1;
   localparam int unsigned RW = DW + 3;

   logic                 en;
   logic signed [AW-1:0] a_re_x, a_im_x, b_re_x, b_im_x;

   logic                 v1_d, v1_q, scale1_d, scale1_q;
   bfly_mode_e           mode1_d, mode1_q;
   logic [TAGW-1:0]      tag1_d, tag1_q;
   logic signed [AW-1:0] s1_re_d, s1_re_q, s1_im_d, s1_im_q;
   logic signed [AW-1:0] d1_re_d, d1_re_q, d1_im_d, d1_im_q;
   logic signed [TW-1:0] w1_re_d, w1_re_q, w1_im_d, w1_im_q;
   logic signed [PW-1:0] p1_re, p1_im, p2_re, p2_im;

   logic                 v2_d, v2_q, scale2_d, scale2_q;
   bfly_mode_e           mode2_d, mode2_q;
   logic [TAGW-1:0]      tag2_d, tag2_q;
   logic signed [AW-1:0] s2_re_d, s2_re_q, s2_im_d, s2_im_q;
   logic signed [RW-1:0] r2_re_d, r2_re_q, r2_im_d, r2_im_q;

   logic                 v3_d, v3_q, ovf_hit_d, ovf_hit_q, sticky_d, sticky_q;
   logic [TAGW-1:0]      tag3_d, tag3_q;
   logic signed [DW-1:0] x_re_d, x_re_q, x_im_d, x_im_q, y_re_d, y_re_q, y_im_d, y_im_q;
   logic signed [63:0]   pre [4];
   logic signed [63:0]   scl [4];
   logic signed [DW-1:0] fin [4];
   logic                 sat_any;

   assign en       = ~v3_q | out_ready;
   assign in_ready = en;
   assign a_re_x   = AW'(a_re);
   assign a_im_x   = AW'(a_im);
   assign b_re_x   = AW'(b_re);
   assign b_im_x   = AW'(b_im);

   // DIT multiplies b*w in S1; DIF multiplies (a-b)*w in S2.
   fft_cmult_pipe #(.AW(AW), .TW(TW)) u_cmult_dit (
      .clk (clk), .rst_n (rst_n), .en_i (en),
      .ar_i (b_re_x), .ai_i (b_im_x), .wr_i (w_re), .wi_i (w_im),
      .pr_o (p1_re), .pi_o (p1_im)
   );

   fft_cmult_pipe #(.AW(AW), .TW(TW)) u_cmult_dif (
      .clk (clk), .rst_n (rst_n), .en_i (en),
      .ar_i (d1_re_q), .ai_i (d1_im_q), .wr_i (w1_re_q), .wi_i (w1_im_q),
      .pr_o (p2_re), .pi_o (p2_im)
   );

   always_comb begin
      v1_d = v1_q; mode1_d = mode1_q; scale1_d = scale1_q; tag1_d = tag1_q;
      s1_re_d = s1_re_q; s1_im_d = s1_im_q; d1_re_d = d1_re_q; d1_im_d = d1_im_q;
      w1_re_d = w1_re_q; w1_im_d = w1_im_q;
      v2_d = v2_q; mode2_d = mode2_q; scale2_d = scale2_q; tag2_d = tag2_q;
      s2_re_d = s2_re_q; s2_im_d = s2_im_q; r2_re_d = r2_re_q; r2_im_d = r2_im_q;
      if (en) begin
         v1_d     = in_valid;
         mode1_d  = in_mode ? BFLY_DIT : BFLY_DIF;
         scale1_d = in_scale;
         tag1_d   = in_tag;
         s1_re_d  = (mode1_d == BFLY_DIT) ? a_re_x : a_re_x + b_re_x;
         s1_im_d  = (mode1_d == BFLY_DIT) ? a_im_x : a_im_x + b_im_x;
         d1_re_d  = a_re_x - b_re_x;
         d1_im_d  = a_im_x - b_im_x;
         w1_re_d  = w_re;
         w1_im_d  = w_im;
         v2_d     = v1_q;
         mode2_d  = mode1_q;
         scale2_d = scale1_q;
         tag2_d   = tag1_q;
         s2_re_d  = s1_re_q;
         s2_im_d  = s1_im_q;
         r2_re_d  = RW'(rnd_shift(64'(p1_re), TW - 1));
         r2_im_d  = RW'(rnd_shift(64'(p1_im), TW - 1));
      end
   end

   always_comb begin
      if (mode2_q == BFLY_DIF) begin
         pre[0] = 64'(s2_re_q);
         pre[1] = 64'(s2_im_q);
         pre[2] = rnd_shift(64'(p2_re), TW - 1);
         pre[3] = rnd_shift(64'(p2_im), TW - 1);
      end else begin
         pre[0] = 64'(s2_re_q) + 64'(r2_re_q);
         pre[1] = 64'(s2_im_q) + 64'(r2_im_q);
         pre[2] = 64'(s2_re_q) - 64'(r2_re_q);
         pre[3] = 64'(s2_im_q) - 64'(r2_im_q);
      end
      sat_any = 1'b0;
      for (int k = 0; k < 4; k++) begin
         scl[k] = scale2_q ? rnd_shift(pre[k], 1) : pre[k];
         fin[k] = DW'(sat_dw(scl[k], DW));
         if (64'(fin[k]) != scl[k]) sat_any = 1'b1;
      end
      v3_d = v3_q; tag3_d = tag3_q;
      x_re_d = x_re_q; x_im_d = x_im_q; y_re_d = y_re_q; y_im_d = y_im_q;
      ovf_hit_d = 1'b0;
      if (en) begin
         v3_d      = v2_q;
         tag3_d    = tag2_q;
         x_re_d    = fin[0];
         x_im_d    = fin[1];
         y_re_d    = fin[2];
         y_im_d    = fin[3];
         ovf_hit_d = v2_q & sat_any;
      end
      // Clear wins over a set arriving in the same cycle.
      sticky_d = ovf_clr ? 1'b0 : (sticky_q | ovf_hit_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0; mode1_q <= BFLY_DIF; scale1_q <= 1'b0; tag1_q <= '0;
         s1_re_q <= '0; s1_im_q <= '0; d1_re_q <= '0; d1_im_q <= '0;
         w1_re_q <= '0; w1_im_q <= '0;
         v2_q <= 1'b0; mode2_q <= BFLY_DIF; scale2_q <= 1'b0; tag2_q <= '0;
         s2_re_q <= '0; s2_im_q <= '0; r2_re_q <= '0; r2_im_q <= '0;
         v3_q <= 1'b0; tag3_q <= '0; ovf_hit_q <= 1'b0; sticky_q <= 1'b0;
         x_re_q <= '0; x_im_q <= '0; y_re_q <= '0; y_im_q <= '0;
      end else begin
         v1_q <= v1_d; mode1_q <= mode1_d; scale1_q <= scale1_d; tag1_q <= tag1_d;
         s1_re_q <= s1_re_d; s1_im_q <= s1_im_d; d1_re_q <= d1_re_d; d1_im_q <= d1_im_d;
         w1_re_q <= w1_re_d; w1_im_q <= w1_im_d;
         v2_q <= v2_d; mode2_q <= mode2_d; scale2_q <= scale2_d; tag2_q <= tag2_d;
         s2_re_q <= s2_re_d; s2_im_q <= s2_im_d; r2_re_q <= r2_re_d; r2_im_q <= r2_im_d;
         v3_q <= v3_d; tag3_q <= tag3_d; ovf_hit_q <= ovf_hit_d; sticky_q <= sticky_d;
         x_re_q <= x_re_d; x_im_q <= x_im_d; y_re_q <= y_re_d; y_im_q <= y_im_d;
      end
   end

   assign out_valid  = v3_q;
   assign out_tag    = tag3_q;
   assign x_re       = x_re_q;
   assign x_im       = x_im_q;
   assign y_re       = y_re_q;
   assign y_im       = y_im_q;
   assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fft_bfly_r2_pipe.sv
// Scoreboard bench for fft_bfly_r2_pipe: a driver pushes expected results on acceptance,
// a monitor pops and compares on every output handshake.
module tb_fft_bfly_r2_pipe;

   localparam int DW = 16;
   localparam int TW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready, in_mode = 1'b0, in_scale = 1'b0;
   logic out_valid, out_ready, ovf_sticky, ovf_clr = 1'b0;
   logic [7:0] in_tag = '0, out_tag;
   logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
   logic signed [15:0] x_re, x_im, y_re, y_im;

   typedef struct {
      logic signed [15:0] ar, ai, br, bi, wr, wi;
      logic mode, scale;
      logic [7:0] tag;
   } smp_t;

   typedef struct {
      logic signed [15:0] xr, xi, yr, yi;
      logic [7:0] tag;
      logic ovf, chk_lat;
      int acc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int checks = 0, errs = 0, n_out = 0, n_stall = 0, cyc = 0, rdy_mode = 0;
   bit held = 0, exp_sticky = 0;
   logic [63:0] held_xy;
   logic [7:0] held_tag;

   fft_bfly_r2_pipe #(.DW(16), .TW(16), .TAGW(8)) dut (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
      .in_mode (in_mode), .in_scale (in_scale), .in_tag (in_tag),
      .a_re (a_re), .a_im (a_im), .b_re (b_re), .b_im (b_im), .w_re (w_re), .w_im (w_im),
      .out_valid (out_valid), .out_ready (out_ready),
      .x_re (x_re), .x_im (x_im), .y_re (y_re), .y_im (y_im), .out_tag (out_tag),
      .ovf_sticky (ovf_sticky), .ovf_clr (ovf_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint got, input longint expv);
      checks++;
      if (got !== expv) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
      end
   endtask

   // Floor((v + 2^(sh-1)) / 2^sh) via plain integer division.
   function automatic longint rhu(input longint v, input int sh);
      longint d, n, r;
      d = longint'(1) << sh;
      n = v + d / 2;
      r = n / d;
      if ((n % d) != 0 && n < 0) r = r - 1;
      return r;
   endfunction

   function automatic exp_t model(input smp_t s);
      exp_t e;
      longint ar, ai, br, bi, wr, wi, pr, pim;
      longint v[4];
      ar = longint'(s.ar); ai = longint'(s.ai); br = longint'(s.br); bi = longint'(s.bi);
      wr = longint'(s.wr); wi = longint'(s.wi);
      if (!s.mode) begin
         pr  = rhu((ar - br) * wr - (ai - bi) * wi, TW - 1);
         pim = rhu((ar - br) * wi + (ai - bi) * wr, TW - 1);
         v[0] = ar + br; v[1] = ai + bi; v[2] = pr; v[3] = pim;
      end else begin
         pr  = rhu(br * wr - bi * wi, TW - 1);
         pim = rhu(br * wi + bi * wr, TW - 1);
         v[0] = ar + pr; v[1] = ai + pim; v[2] = ar - pr; v[3] = ai - pim;
      end
      e.ovf = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (s.scale) v[k] = rhu(v[k], 1);
         if (v[k] > 32767) begin v[k] = 32767; e.ovf = 1'b1; end
         else if (v[k] < -32768) begin v[k] = -32768; e.ovf = 1'b1; end
      end
      e.xr = 16'(v[0]); e.xi = 16'(v[1]); e.yr = 16'(v[2]); e.yi = 16'(v[3]);
      e.tag = s.tag; e.chk_lat = 1'b0; e.acc = 0;
      return e;
   endfunction

   function automatic smp_t mk(input int ar, ai, br, bi, wr, wi, input bit mode, scale,
                               input int tag);
      smp_t s;
      s.ar = 16'(ar); s.ai = 16'(ai); s.br = 16'(br); s.bi = 16'(bi);
      s.wr = 16'(wr); s.wi = 16'(wi); s.mode = mode; s.scale = scale; s.tag = 8'(tag);
      return s;
   endfunction

   function automatic exp_t mkexp(input int xr, xi, yr, yi, tag, input bit ovf);
      exp_t e;
      e.xr = 16'(xr); e.xi = 16'(xi); e.yr = 16'(yr); e.yi = 16'(yi);
      e.tag = 8'(tag); e.ovf = ovf; e.chk_lat = 1'b1; e.acc = 0;
      return e;
   endfunction

   function automatic smp_t rnd_smp(input int tag, input bit mode);
      smp_t s;
      s.ar = 16'($urandom); s.ai = 16'($urandom); s.br = 16'($urandom); s.bi = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
         s.wr = 16'sd32767; s.wi = 16'sd0;
      end else begin
         s.wr = 16'($urandom); s.wi = 16'($urandom);
      end
      s.mode = mode; s.scale = 1'($urandom_range(0, 1)); s.tag = 8'(tag);
      return s;
   endfunction

   task automatic send(input smp_t s, input exp_t e);
      int w;
      @(posedge clk); #1;
      in_valid = 1'b1; in_mode = s.mode; in_scale = s.scale; in_tag = s.tag;
      a_re = s.ar; a_im = s.ai; b_re = s.br; b_im = s.bi; w_re = s.wr; w_im = s.wi;
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 100) begin @(negedge clk); w++; end
      if (!in_ready) begin
         checks++; errs++;
         $display("FAIL in_ready_timeout: got 0 expected 1 within 100 cycles");
      end else begin
         e.acc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic send_m(input smp_t s);
      send(s, model(s));
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; in_valid = 1'b0; end
   endtask

   task automatic drain();
      int w;
      idle(1);
      w = 0;
      while (q.size() != 0 && w < 400) begin @(negedge clk); w++; end
      if (q.size() != 0) begin
         checks++; errs++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            1:       out_ready = (cyc % 3 == 0);
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         held = 0;
      end else begin
         chk("in_ready", in_ready, !out_valid || out_ready);
         if (held) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_xy", {x_re, x_im, y_re, y_im}, held_xy);
            chk("stall_tag", out_tag, held_tag);
         end
         if (out_valid && out_ready) begin
            n_out++;
            held = 0;
            if (q.size() == 0) begin
               checks++; errs++;
               $display("FAIL spurious_output: got tag %0d expected no output", out_tag);
            end else begin
               mon_e = q.pop_front();
               chk("x_re", x_re, mon_e.xr);
               chk("x_im", x_im, mon_e.xi);
               chk("y_re", y_re, mon_e.yr);
               chk("y_im", y_im, mon_e.yi);
               chk("out_tag", out_tag, mon_e.tag);
               if (mon_e.chk_lat) chk("latency", cyc - mon_e.acc, 3);
               exp_sticky = exp_sticky | mon_e.ovf;
            end
         end else if (out_valid) begin
            n_stall++;
            held = 1;
            held_xy = {x_re, x_im, y_re, y_im};
            held_tag = out_tag;
         end else begin
            held = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n0;
      smp_t s;
      // Reset state.
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ovf", ovf_sticky, 0);
      chk("rst_xy", {x_re, x_im, y_re, y_im}, 0);
      chk("rst_tag", out_tag, 0);

      // Directed arithmetic examples.
      send(mk(1000, -200, 300, 100, 32767, 0, 0, 0, 1), mkexp(1300, -100, 700, -300, 1, 0));
      send(mk(0, 0, 100, 50, 0, -32767, 1, 1, 2), mkexp(25, -50, -25, 50, 2, 0));
      drain();

      // Saturation sets the sticky flag; clear drops it.
      send(mk(32767, -32768, 32767, -32768, 32767, 0, 0, 0, 3),
           mkexp(32767, -32768, 0, 0, 3, 1));
      drain();
      idle(2);
      @(negedge clk);
      chk("ovf_set", ovf_sticky, 1);
      @(posedge clk); #1 ovf_clr = 1'b1;
      @(posedge clk); #1 ovf_clr = 1'b0;
      @(negedge clk);
      chk("ovf_clear", ovf_sticky, 0);
      send(mk(32767, -32768, 32767, -32768, 32767, 0, 0, 1, 4),
           mkexp(32767, -32768, 0, 0, 4, 0));
      drain();
      idle(2);
      @(negedge clk);
      chk("ovf_scaled_none", ovf_sticky, 0);

      // Clear held across a saturating result must keep the flag low throughout.
      @(posedge clk); #1 ovf_clr = 1'b1;
      send(mk(32767, 32767, 32767, 32767, 32767, 0, 0, 0, 5),
           mkexp(32767, 32767, 0, 0, 5, 1));
      drain();
      repeat (4) begin @(negedge clk); chk("clr_priority", ovf_sticky, 0); end
      @(posedge clk); #1 ovf_clr = 1'b0;
      @(negedge clk);
      chk("clr_priority_after", ovf_sticky, 0);

      // Reset with two samples in flight: neither may emerge.
      send_m(rnd_smp(8'hA0, 0));
      send_m(rnd_smp(8'hA1, 1));
      @(posedge clk); #1;
      rst_n = 1'b0; in_valid = 1'b0;
      q.delete();
      n0 = n_out;
      @(negedge clk);
      chk("rst_async_valid", out_valid, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(10);
      @(negedge clk);
      chk("rst_flush_outputs", n_out - n0, 0);
      chk("rst_flush_ovf", ovf_sticky, 0);

      // Backpressure: ready pattern 1,0,0 with tags 0..9 back-to-back.
      rdy_mode = 1;
      n0 = n_stall;
      for (int i = 0; i < 10; i++) send_m(rnd_smp(i, 1'($urandom_range(0, 1))));
      drain();
      chk("bp_stalls_seen", (n_stall > n0) ? 1 : 0, 1);
      rdy_mode = 0;

      // Alternating modes every cycle.
      for (int i = 0; i < 20; i++) send_m(rnd_smp(100 + i, 1'(i % 2)));
      drain();

      // Randomised traffic with random ready; sticky compared against the model.
      @(posedge clk); #1 ovf_clr = 1'b1;
      @(posedge clk); #1 ovf_clr = 1'b0;
      exp_sticky = 0;
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         send_m(rnd_smp(i & 255, 1'($urandom_range(0, 1))));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      drain();
      rdy_mode = 0;
      idle(3);
      @(negedge clk);
      chk("sticky_model", ovf_sticky, exp_sticky);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
